// File: rtl/pio_master.sv
// pio_master: PIO bus initiator.
//
// Turns single-word host read/write requests into PIO beats, waits for the
// responder's completion with a timeout, and returns the result to the host.
// Exactly one transaction is outstanding at a time.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   clk_div                  beat enable; PIO outputs only change on edges where it is 1
//   req_valid/req_ready      host request handshake (req_rw, req_addr, req_wdata)
//   resp_valid/resp_ready    host completion handshake (resp_rdata, resp_err)
//   pio_start/pio_rw/pio_addr_wdata   outgoing beats: address beat, then write data
//   pio_ack/pio_rvalid/pio_rdata      responder completion inputs
//   txn_cnt/timeout_cnt/stray_cnt     saturating statistics counters
module pio_master #(
    parameter int PIO_W       = 32,
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_div,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_rw,
    input  logic [PIO_W-1:0] req_addr,
    input  logic [PIO_W-1:0] req_wdata,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [PIO_W-1:0] resp_rdata,
    output logic             resp_err,
    output logic             pio_start,
    output logic             pio_rw,
    output logic [PIO_W-1:0] pio_addr_wdata,
    input  logic             pio_ack,
    input  logic             pio_rvalid,
    input  logic [PIO_W-1:0] pio_rdata,
    output logic [CNT_W-1:0] txn_cnt,
    output logic [CNT_W-1:0] timeout_cnt,
    output logic [CNT_W-1:0] stray_cnt
);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_WAIT, S_RESP} state_t;

    state_t           state;
    state_t           state_nxt;

    logic             rw_q;
    logic [PIO_W-1:0] addr_q;
    logic [PIO_W-1:0] wdata_q;
    logic             addr_sent;   // address beat is on the bus (ADDR state)
    logic [15:0]      tmo_q;

    logic             launch;
    logic             beat_adv;
    logic             done;
    logic             tmo_hit;
    logic             stray;
    logic             resp_take;

    // The address beat goes out on the first enabled edge: either the accept
    // edge itself or a later one if clk_div was low when the request arrived.
    assign launch    = clk_div & (((state == S_IDLE) & req_valid) |
                                  ((state == S_ADDR) & ~addr_sent));
    assign beat_adv  = clk_div & (state == S_ADDR) & addr_sent;
    // Reads complete on rvalid only; an early ack is legal and ignored.
    assign done      = (state == S_WAIT) & (rw_q ? pio_rvalid : pio_ack);
    assign tmo_hit   = (state == S_WAIT) & (tmo_q == 16'(TIMEOUT_CYC - 1));
    assign stray     = (state != S_WAIT) & (pio_ack | pio_rvalid);
    assign resp_take = resp_valid & resp_ready;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // State register.
    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    // NOTE: state_nxt is defaulted before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (req_valid)        state_nxt = S_ADDR;
            S_ADDR: if (beat_adv)         state_nxt = rw_q ? S_WAIT : S_DATA;
            S_DATA: if (clk_div)          state_nxt = S_WAIT;
            S_WAIT: if (done || tmo_hit)  state_nxt = S_RESP;
            S_RESP: if (resp_ready)       state_nxt = S_IDLE;
            default:                      state_nxt = S_IDLE;
        endcase
    end

    // Host-side handshake outputs are pure functions of the state.
    always_comb begin
        req_ready  = (state == S_IDLE);
        resp_valid = (state == S_RESP);
    end

    // Request holding registers.
    // NOTE: these carry no reset; they are always written on acceptance before
    // anything reads them.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && req_valid) begin
            rw_q    <= req_rw;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    // PIO beat outputs. On the accept edge the request registers are not yet
    // loaded, so the beat is taken straight from the request port.
    always_ff @(posedge clk) begin
        if (rst) begin
            pio_start      <= 1'b0;
            pio_rw         <= 1'b0;
            pio_addr_wdata <= '0;
            addr_sent      <= 1'b0;
        end else if (launch) begin
            pio_start      <= 1'b1;
            addr_sent      <= 1'b1;
            pio_rw         <= (state == S_IDLE) ? req_rw   : rw_q;
            pio_addr_wdata <= (state == S_IDLE) ? req_addr : addr_q;
        end else if (beat_adv) begin
            pio_start      <= 1'b0;
            pio_rw         <= 1'b0;
            pio_addr_wdata <= rw_q ? '0 : wdata_q;
        end else if (clk_div && state == S_DATA) begin
            pio_addr_wdata <= '0;
        end else if (state == S_IDLE) begin
            addr_sent      <= 1'b0;
        end
    end

    // Completion capture, timeout counter and statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q       <= '0;
            resp_rdata  <= '0;
            resp_err    <= 1'b0;
            txn_cnt     <= '0;
            timeout_cnt <= '0;
            stray_cnt   <= '0;
        end else begin
            tmo_q <= (state == S_WAIT) ? tmo_q + 16'd1 : 16'd0;

            // Completion takes priority over a timeout in the same cycle.
            if (done) begin
                resp_rdata <= rw_q ? pio_rdata : '0;
                resp_err   <= 1'b0;
            end else if (tmo_hit) begin
                resp_rdata  <= '0;
                resp_err    <= 1'b1;
                timeout_cnt <= sat_inc(timeout_cnt);
            end else if (resp_take) begin
                resp_rdata <= '0;
                resp_err   <= 1'b0;
            end

            if (resp_take) txn_cnt   <= sat_inc(txn_cnt);
            if (stray)     stray_cnt <= sat_inc(stray_cnt);
        end
    end

endmodule

// File: tb/tb_pio_master.sv
// Self-checking bench for pio_master (TIMEOUT_CYC = 8). Expected completions
// are queued when a request is issued and compared by a monitor when the
// host handshake fires.
module tb_pio_master;

    localparam int PIO_W = 32;
    localparam int CNT_W = 16;
    localparam int TMO   = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             clk_div;
    logic             req_valid;
    logic             req_ready;
    logic             req_rw;
    logic [PIO_W-1:0] req_addr;
    logic [PIO_W-1:0] req_wdata;
    logic             resp_valid;
    logic             resp_ready;
    logic [PIO_W-1:0] resp_rdata;
    logic             resp_err;
    logic             pio_start;
    logic             pio_rw;
    logic [PIO_W-1:0] pio_addr_wdata;
    logic             pio_ack;
    logic             pio_rvalid;
    logic [PIO_W-1:0] pio_rdata;
    logic [CNT_W-1:0] txn_cnt;
    logic [CNT_W-1:0] timeout_cnt;
    logic [CNT_W-1:0] stray_cnt;

    pio_master #(.PIO_W(PIO_W), .TIMEOUT_CYC(TMO), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .clk_div        (clk_div),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_rw         (req_rw),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .pio_start      (pio_start),
        .pio_rw         (pio_rw),
        .pio_addr_wdata (pio_addr_wdata),
        .pio_ack        (pio_ack),
        .pio_rvalid     (pio_rvalid),
        .pio_rdata      (pio_rdata),
        .txn_cnt        (txn_cnt),
        .timeout_cnt    (timeout_cnt),
        .stray_cnt      (stray_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [PIO_W-1:0] rdata;
        logic             err;
    } resp_t;

    resp_t sb[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    bit    div_toggle = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Inputs are driven and outputs sampled 1 time unit after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (div_toggle) clk_div = ~clk_div;
    endtask

    task automatic issue(input logic rw, input logic [PIO_W-1:0] addr,
                         input logic [PIO_W-1:0] wdata);
        req_valid = 1'b1;
        req_rw    = rw;
        req_addr  = addr;
        req_wdata = wdata;
    endtask

    // Completion monitor: every accepted response must match the queue head.
    always @(negedge clk) begin
        resp_t e;
        if (!rst && resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_resp", 1, 0);
            end else begin
                e = sb.pop_front();
                check("resp_rdata", resp_rdata, e.rdata);
                check("resp_err", resp_err, e.err);
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst = 1'b1; clk_div = 1'b1; req_valid = 1'b0; req_rw = 1'b0;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
        pio_ack = 1'b0; pio_rvalid = 1'b0; pio_rdata = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_pio_start", pio_start, 0);
        check("rst_pio_bus", pio_addr_wdata, 0);
        check("rst_txn_cnt", txn_cnt, 0);

        // Write, clk_div=1, ack two cycles after the data beat
        issue(1'b0, 32'h0000_0104, 32'hCAFE_0001);
        sb.push_back('{rdata: '0, err: 1'b0});
        tick(); req_valid = 1'b0;
        check("wr_start", pio_start, 1);
        check("wr_rw", pio_rw, 0);
        check("wr_addr", pio_addr_wdata, 32'h0000_0104);
        check("wr_req_ready", req_ready, 0);
        tick();
        check("wr_start_low", pio_start, 0);
        check("wr_data", pio_addr_wdata, 32'hCAFE_0001);
        tick();
        check("wr_bus_idle", pio_addr_wdata, 0);
        tick(); pio_ack = 1'b1;
        tick(); pio_ack = 1'b0;
        check("wr_resp_valid", resp_valid, 1);
        tick();
        check("wr_txn_cnt", txn_cnt, 1);
        check("wr_stray", stray_cnt, 0);

        // Read at minimum latency: rvalid on the first WAIT cycle
        issue(1'b1, 32'h0000_0010, '0);
        sb.push_back('{rdata: 32'hA5A5_0003, err: 1'b0});
        tick(); req_valid = 1'b0;
        check("rd0_rw", pio_rw, 1);
        check("rd0_addr", pio_addr_wdata, 32'h10);
        tick(); pio_rvalid = 1'b1; pio_rdata = 32'hA5A5_0003;
        check("rd0_not_yet", resp_valid, 0);
        tick(); pio_rvalid = 1'b0;
        check("rd0_latency3", resp_valid, 1);
        tick();

        // Read with clk_div toggling; early ack is not stray
        clk_div = 1'b1; div_toggle = 1'b1;
        issue(1'b1, 32'h0000_0200, '0);
        sb.push_back('{rdata: 32'h1234_5678, err: 1'b0});
        tick(); req_valid = 1'b0;
        check("rd_start_c1", pio_start, 1);
        check("rd_addr_c1", pio_addr_wdata, 32'h200);
        tick();
        check("rd_start_c2", pio_start, 1);
        check("rd_addr_c2", pio_addr_wdata, 32'h200);
        tick();
        check("rd_start_end", pio_start, 0);
        check("rd_bus_zero", pio_addr_wdata, 0);
        tick(); pio_ack = 1'b1;
        tick(); pio_ack = 1'b0;
        tick(); pio_rvalid = 1'b1; pio_rdata = 32'h1234_5678;
        tick(); pio_rvalid = 1'b0;
        check("rd_resp_valid", resp_valid, 1);
        tick(); div_toggle = 1'b0; clk_div = 1'b1;
        check("rd_stray", stray_cnt, 0);
        check("rd_txn_cnt", txn_cnt, 3);

        // Timeout: no response at all
        issue(1'b1, 32'h0000_0300, '0);
        sb.push_back('{rdata: '0, err: 1'b1});
        tick(); req_valid = 1'b0;
        tick();
        n = 0;
        while (!resp_valid && n < 20) begin
            tick();
            n++;
        end
        check("tmo_latency", n, TMO);
        check("tmo_err", resp_err, 1);
        tick();
        check("tmo_cnt", timeout_cnt, 1);
        check("tmo_txn_cnt", txn_cnt, 4);
        pio_rvalid = 1'b1;
        tick(); pio_rvalid = 1'b0;
        tick();
        check("late_stray", stray_cnt, 1);
        check("late_no_resp", resp_valid, 0);

        // Backpressure, then second request waits for the handshake
        resp_ready = 1'b0;
        issue(1'b0, 32'h0000_0040, 32'h55AA_55AA);
        sb.push_back('{rdata: '0, err: 1'b0});
        tick(); req_valid = 1'b0;
        tick();
        tick(); pio_ack = 1'b1;
        tick(); pio_ack = 1'b0;
        issue(1'b1, 32'h0000_0088, '0);
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", resp_valid, 1);
            check("bp_err", resp_err, 0);
            check("bp_rdata", resp_rdata, 0);
            check("bp_req_ready", req_ready, 0);
            tick();
        end
        resp_ready = 1'b1;
        tick();
        check("bp_ready_after", req_ready, 1);
        check("bp_not_started", pio_start, 0);
        tick(); req_valid = 1'b0;
        check("bp_second_start", pio_start, 1);
        check("bp_second_addr", pio_addr_wdata, 32'h88);

        // Reset in WAIT: dropped, no response
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        check("mid_rst_req_ready", req_ready, 1);
        check("mid_rst_resp_valid", resp_valid, 0);
        check("mid_rst_start", pio_start, 0);
        check("mid_rst_rw", pio_rw, 0);
        check("mid_rst_bus", pio_addr_wdata, 0);
        check("mid_rst_txn", txn_cnt, 0);
        check("mid_rst_tmo", timeout_cnt, 0);
        check("mid_rst_stray", stray_cnt, 0);
        repeat (TMO + 4) tick();
        check("mid_rst_silent", resp_valid, 0);

        // Stray counter saturation in IDLE
        pio_ack = 1'b1;
        repeat (65534) tick();
        check("sat_pre", stray_cnt, 16'hFFFE);
        tick();
        check("sat_hit", stray_cnt, 16'hFFFF);
        repeat (5) tick();
        check("sat_hold", stray_cnt, 16'hFFFF);
        check("sat_txn", txn_cnt, 0);
        pio_ack = 1'b0;
        tick();

        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pio_master.md
Name: pio_master

Overview:
- PIO bus initiator. Converts single-word register read/write requests from a local host-side port into pio_start/pio_rw/pio_addr_wdata beats.
- Collects pio_ack, pio_rvalid and pio_rdata from the responder block, such as a block top containing pio2reg_bus.
- Sits in the CPU/PCIe bridge path and fans into one responder or an OR-combined responder group.
- Provides response-timeout protection and saturating statistics counters.

Parameters:
- PIO_W, 32: width of pio_addr_wdata, pio_rdata, address and data.
- TIMEOUT_CYC, 1024: clk cycles to wait for completion after the last beat; legal range 2..65535.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  clock.
- `RESET_SIG  in  1  synchronous, active-high reset.
- clk_div  in  1  beat enable: PIO outputs change only on clk cycles where clk_div=1.
- req_valid  in  1  host request valid.
- req_ready  out  1  request accepted when req_valid&req_ready.
- req_rw  in  1  1=read, 0=write.
- req_addr  in  PIO_W  register/memory address.
- req_wdata  in  PIO_W  write data; ignored for reads.
- resp_valid  out  1  completion valid; held until resp_ready.
- resp_ready  in  1  host accepts completion.
- resp_rdata  out  PIO_W  read data; 0 for writes and on timeout.
- resp_err  out  1  1 = timed out.
- pio_start  out  1  first beat of a transaction.
- pio_rw  out  1  1=read, 0=write; valid with pio_start.
- pio_addr_wdata  out  PIO_W  address beat, then write-data beat.
- pio_ack  in  1  responder acknowledge.
- pio_rvalid  in  1  read data valid.
- pio_rdata  in  PIO_W  read data.
- txn_cnt  out  CNT_W  completed transactions, saturating.
- timeout_cnt  out  CNT_W  timed-out transactions, saturating.
- stray_cnt  out  CNT_W  pio_ack or pio_rvalid seen outside WAIT, saturating.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0; applies immediately on the next clk edge, including mid-transaction. An in-flight transaction is dropped with no response.
- States: IDLE, ADDR, DATA, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch rw/addr/wdata and go to ADDR. req_ready drops the following cycle.
  - Exactly one outstanding transaction.
- ADDR:
  - On the first cycle with clk_div=1, drive pio_start=1, pio_rw=rw, pio_addr_wdata=addr.
  - Outputs hold until the next clk_div=1 cycle.
  - At that cycle: write → DATA, driving pio_start=0, pio_addr_wdata=wdata; read → WAIT, driving pio_start=0, pio_addr_wdata=0.
- DATA:
  - Hold wdata until the next clk_div=1 cycle.
  - Then drive pio_addr_wdata=0 and go to WAIT.
- WAIT:
  - Timeout counter loads 0 on entry and increments every clk.
  - Write completes on the first cycle with pio_ack=1.
  - Read completes on the first cycle with pio_rvalid=1; capture pio_rdata that cycle. pio_ack before or with pio_rvalid is permitted and ignored for reads.
  - Responses are sampled every clk, independent of clk_div.
  - Acks arriving during ADDR/DATA of the same transaction are counted as stray and do not complete it.
  - If the counter reaches TIMEOUT_CYC-1 without completion: resp_err=1, resp_rdata=0, timeout_cnt++, go to RESP.
  - Completion and timeout in the same cycle: completion wins.
- RESP:
  - resp_valid=1 with stable resp_rdata/resp_err until resp_valid&resp_ready.
  - On acceptance: txn_cnt++ (also on timeouts), go to IDLE. resp_valid deasserts on the next cycle.
- Late or unsolicited pio_ack/pio_rvalid in IDLE/ADDR/DATA/RESP increments stray_cnt (at most 1 per cycle) and is otherwise ignored.
- Counters saturate at all-ones and never wrap.
- clk_div held at 1: a write occupies 2 cycles of beats, a read 1 cycle of beats.
- Minimum latency, request accept to resp_valid, with clk_div=1 and a same-cycle ack: write 4 clk, read 3 clk.

Test Plan:
- Write, clk_div=1: req addr=0x0000_0104, wdata=0xCAFE_0001; responder pio_ack 2 cycles after data beat → pio_start high 1 cycle with pio_rw=0 and 0x104, then 0xCAFE_0001; resp_valid, resp_err=0, resp_rdata=0; txn_cnt=1.
- Read, clk_div toggling 1/0: req addr=0x200; pio_ack at +3, pio_rvalid with pio_rdata=0x1234_5678 at +5 → each beat held 2 clk; resp_rdata=0x1234_5678; the earlier pio_ack is not stray.
- Timeout, TIMEOUT_CYC=8: read with no response → resp_valid exactly 8 clk after WAIT entry, resp_err=1, resp_rdata=0, timeout_cnt=1. A late pio_rvalid after that → stray_cnt=1, no second response.
- Backpressure: resp_ready=0 for 10 cycles → resp_valid and data stable, req_ready=0, a second req_valid not accepted until 1 cycle after the handshake.
- Reset mid-WAIT: assert `RESET_SIG in WAIT → next cycle all outputs 0, state IDLE, req_ready=1, no response emitted.
- Saturation: force 65536 stray acks in IDLE → stray_cnt=0xFFFF, stays 0xFFFF.
